// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, byte-wide instruction memory with loader port, IF/ID register.
// Optional performance counters are compiled in with `define IF_PERF_CNT_EN.
module if_stage #(
  parameter int          IMEM_BYTES = 256,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          branch_taken,
  input  logic [63:0]                   branch_target,
  input  logic                          imem_wr_en,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_wr_addr,
  input  logic [7:0]                    imem_wr_data,
  output logic [63:0]                   PC_Out,
  output logic [31:0]                   Instruction,
  output logic [63:0]                   IFID_PC,
  output logic [31:0]                   IFID_Instruction,
  output logic                          IFID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0]  mem [IMEM_BYTES];

  logic [63:0] pc_reg, pc_next;
  logic [63:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic        ifid_valid_reg, ifid_valid_next;

  // Branch targets are forced word-aligned, so the low two bits are never consumed.
  logic        unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk) begin
    if (imem_wr_en) begin
      mem[imem_wr_addr] <= imem_wr_data;
    end
  end

  // Little-endian word fetch; the index wraps modulo the memory size.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fetch_byte
      logic [AW-1:0] byte_addr;
      assign byte_addr = {pc_reg[AW-1:2], 2'(gi)};
      assign Instruction[8*gi +: 8] = mem[byte_addr];
    end
  endgenerate

  always_comb begin
    pc_next         = pc_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_valid_next = ifid_valid_reg;
    if (branch_taken) begin
      pc_next         = {branch_target[63:2], 2'b00};
      ifid_pc_next    = 64'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
    end else if (flush) begin
      if (!stall) begin
        pc_next = pc_reg + 64'd4;
      end
      ifid_pc_next    = 64'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
    end else if (!stall) begin
      pc_next         = pc_reg + 64'd4;
      ifid_pc_next    = pc_reg;
      ifid_instr_next = Instruction;
      ifid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      ifid_pc_reg    <= 64'h0;
      ifid_instr_reg <= NOP_INSTR;
      ifid_valid_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  assign PC_Out           = pc_reg;
  assign IFID_PC          = ifid_pc_reg;
  assign IFID_Instruction = ifid_instr_reg;
  assign IFID_valid       = ifid_valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_reg, stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_reg <= 32'h0;
      stall_count_reg <= 32'h0;
    end else if (!branch_taken && !flush) begin
      if (stall) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end else begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, flush, wrap, loader and async reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [7:0]  imem_wr_data;
  logic [63:0] PC_Out;
  logic [31:0] Instruction;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instruction;
  logic        IFID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  if_stage #(
    .IMEM_BYTES(256),
    .RESET_PC  (64'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_wr_en      (imem_wr_en),
    .imem_wr_addr    (imem_wr_addr),
    .imem_wr_data    (imem_wr_data),
    .PC_Out          (PC_Out),
    .Instruction     (Instruction),
    .IFID_PC         (IFID_PC),
    .IFID_Instruction(IFID_Instruction),
    .IFID_valid      (IFID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      $display("check %-18s observed=%h expected=%h ok", tag, observed, expected);
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      imem_wr_en   = 1'b1;
      imem_wr_addr = addr + 8'(b);
      imem_wr_data = word[8*b +: 8];
      step();
    end
    imem_wr_en = 1'b0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {63'h0, IFID_valid}, 64'h0);
    chk({tag, "_instr"}, {32'h0, IFID_Instruction}, {32'h0, NOP});
    chk({tag, "_ifidpc"}, IFID_PC, 64'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 64'h0; imem_wr_en = 1'b0; imem_wr_addr = 8'h0; imem_wr_data = 8'h0;
    step();

    // Program load while held in reset
    load_word(8'h00, 32'h00500093);
    load_word(8'h04, 32'h00300113);
    load_word(8'h08, 32'h002081B3);
    load_word(8'h20, 32'h12345678);

    chk("rst_pc", PC_Out, 64'h0);
    chk_bubble("rst");
    chk("rst_fetch", {32'h0, Instruction}, 64'h00500093);
`ifdef IF_PERF_CNT_EN
    chk("rst_fcnt", {32'h0, fetch_count}, 64'h0);
    chk("rst_scnt", {32'h0, stall_count}, 64'h0);
`endif

    // Sequential fetch
    reset = 1'b0;
    step();
    chk("e1_ifidpc", IFID_PC, 64'h0);
    chk("e1_instr", {32'h0, IFID_Instruction}, 64'h00500093);
    chk("e1_valid", {63'h0, IFID_valid}, 64'h1);
    chk("e1_pc", PC_Out, 64'h4);
`ifdef IF_PERF_CNT_EN
    chk("e1_fcnt", {32'h0, fetch_count}, 64'h1);
`endif
    step();
    chk("e2_ifidpc", IFID_PC, 64'h4);
    chk("e2_instr", {32'h0, IFID_Instruction}, 64'h00300113);
    chk("e2_pc", PC_Out, 64'h8);

    // Stall two cycles at PC 8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", PC_Out, 64'h8);
      chk("stall_ifidpc", IFID_PC, 64'h4);
    end
`ifdef IF_PERF_CNT_EN
    chk("stall_scnt", {32'h0, stall_count}, 64'h2);
`endif
    stall = 1'b0;
    step();
    chk("e3_ifidpc", IFID_PC, 64'h8);
    chk("e3_instr", {32'h0, IFID_Instruction}, 64'h002081B3);
    chk("e3_pc", PC_Out, 64'hC);

    // Redirect overrides stall
    branch_taken = 1'b1; branch_target = 64'h22; stall = 1'b1;
    step();
    chk("br_pc", PC_Out, 64'h20);
    chk_bubble("br");
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk("br_ifidpc", IFID_PC, 64'h20);
    chk("br_instr", {32'h0, IFID_Instruction}, 64'h12345678);
    chk("br_next_pc", PC_Out, 64'h24);

    // Flush with and without stall
    branch_taken = 1'b1; branch_target = 64'hC;
    step();
    branch_taken = 1'b0;
    step();
    chk("pre_fl_valid", {63'h0, IFID_valid}, 64'h1);
    chk("pre_fl_pc", PC_Out, 64'h10);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flst_pc", PC_Out, 64'h10);
    chk_bubble("flst");
    stall = 1'b0;
    step();
    chk("fl_pc", PC_Out, 64'h14);
    chk_bubble("fl");
    flush = 1'b0;

    // Fetch index wraps modulo memory size, PC does not
    branch_taken = 1'b1; branch_target = 64'h100;
    step();
    branch_taken = 1'b0;
    chk("wrap_pc", PC_Out, 64'h100);
    chk("wrap_fetch", {32'h0, Instruction}, 64'h00500093);
    step();
    chk("wrap_ifidpc", IFID_PC, 64'h100);
    chk("wrap_instr", {32'h0, IFID_Instruction}, 64'h00500093);
    chk("wrap_pc2", PC_Out, 64'h104);
    chk("wrap_fetch2", {32'h0, Instruction}, 64'h00300113);

    // 64-bit PC overflow
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    branch_taken = 1'b0;
    chk("ovf_pc", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("ovf_pc2", PC_Out, 64'h0);
    chk("ovf_ifidpc", IFID_PC, 64'hFFFF_FFFF_FFFF_FFFC);

    // Loader write to the word being fetched: fetch sees old data
    imem_wr_en = 1'b1; imem_wr_addr = 8'h00; imem_wr_data = 8'hAA;
    step();
    imem_wr_en = 1'b0;
    chk("wr_old_instr", {32'h0, IFID_Instruction}, 64'h00500093);
    branch_taken = 1'b1; branch_target = 64'h0;
    step();
    branch_taken = 1'b0;
    chk("wr_new_fetch", {32'h0, Instruction}, 64'h005000AA);

    // Asynchronous reset between edges
    branch_taken = 1'b1; branch_target = 64'h3C;
    step();
    branch_taken = 1'b0;
    step();
    chk("pre_ar_pc", PC_Out, 64'h40);
    chk("pre_ar_valid", {63'h0, IFID_valid}, 64'h1);
    reset = 1'b1;
    #2;
    chk("ar_pc", PC_Out, 64'h0);
    chk_bubble("ar");
`ifdef IF_PERF_CNT_EN
    chk("ar_fcnt", {32'h0, fetch_count}, 64'h0);
    chk("ar_scnt", {32'h0, stall_count}, 64'h0);
`endif
    step();
    reset = 1'b0;
    step();
    chk("post_ar_ifidpc", IFID_PC, 64'h0);
    chk("post_ar_instr", {32'h0, IFID_Instruction}, 64'h005000AA);
    chk("post_ar_pc", PC_Out, 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage for the pipelined RISC-V core. It holds the PC, the byte-addressed instruction memory and the IF/ID pipeline register. It accepts stall from the hazard unit, and flush/redirect from the EX-stage branch resolution. It feeds the decode stage with PC, instruction and a valid bit. The bench loads programs through a byte write port.

Parameters:
IMEM_BYTES, 256, instruction memory size in bytes; power of two, >= 8.
RESET_PC, 64'h0, PC value after reset.
NOP_INSTR, 32'h00000013, encoding used for bubbles (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  squash IF/ID contents (bubble)
branch_taken  input  1  EX-stage redirect request
branch_target  input  64  redirect address
imem_wr_en  input  1  loader byte write enable
imem_wr_addr  input  $clog2(IMEM_BYTES)  loader byte address
imem_wr_data  input  8  loader byte
PC_Out  output  64  current fetch PC
Instruction  output  32  instruction at PC_Out (combinational)
IFID_PC  output  64  registered PC to decode
IFID_Instruction  output  32  registered instruction to decode
IFID_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - PC_Out = RESET_PC.
  - IFID_PC = 0.
  - IFID_Instruction = NOP_INSTR.
  - IFID_valid = 0.
  - Memory contents are not reset.
- Fetch read is combinational and little-endian:
  - Instruction = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - a = PC_Out[$clog2(IMEM_BYTES)-1:0] with bits [1:0] forced to 0, so fetch addresses wrap modulo IMEM_BYTES.
  - PC_Out itself is a full 64-bit value and is not wrapped.
- Loader write: on a rising edge with imem_wr_en=1, mem[imem_wr_addr] <= imem_wr_data.
  - The new byte is visible on Instruction after that edge.
  - A write is allowed at the same time as a fetch of the same word; the fetch in that cycle sees the old data.
- Per-edge update, in priority order:
  1. branch_taken=1:
     - PC_Out <= {branch_target[63:2], 2'b00}.
     - IF/ID <= bubble (IFID_PC=0, IFID_Instruction=NOP_INSTR, IFID_valid=0).
     - Overrides stall and flush.
  2. flush=1 and stall=1: PC_Out held; IF/ID <= bubble.
  3. flush=1 and stall=0: PC_Out <= PC_Out+4; IF/ID <= bubble.
  4. stall=1: PC_Out and all IFID_* held unchanged.
  5. Otherwise:
     - PC_Out <= PC_Out+4.
     - IFID_PC <= PC_Out; IFID_Instruction <= Instruction; IFID_valid <= 1.
- PC arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Fetch latency: an instruction appears on IF/ID one edge after its PC is on PC_Out, provided there is no stall, flush or branch_taken.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock edge. The first fetch after release is from RESET_PC.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds two outputs, fetch_count (32-bit) and stall_count (32-bit). Both reset to 0 and wrap at 2^32.
  - fetch_count increments on every edge where case 5 applies.
  - stall_count increments on every edge where case 4 applies.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset/sequential fetch:
  - Load words 0x00500093, 0x00300113, 0x002081B3 at byte addresses 0, 4, 8.
  - Release reset; after edge 1: IFID_PC=0, IFID_Instruction=0x00500093, IFID_valid=1, PC_Out=4.
  - After edge 3: IFID_PC=8, IFID_Instruction=0x002081B3.
- Stall: assert stall for 2 cycles while PC_Out=8 -> PC_Out stays 8 and IF/ID keeps PC=4 throughout. After release, next edge: IFID_PC=8.
- Branch redirect:
  - branch_taken=1 with branch_target=0x22 and stall=1 -> PC_Out=0x20 and IFID_valid=0, IFID_Instruction=0x00000013.
  - Next edge: IFID_PC=0x20.
- Flush vs stall:
  - flush=1, stall=1 at PC_Out=0x10 -> PC_Out=0x10, IFID_valid=0.
  - flush=1 alone -> PC_Out=0x14, IFID_valid=0.
- Wrap: with IMEM_BYTES=256, set PC to 0x100 via branch -> Instruction equals the word at byte 0; PC_Out=0x100, then 0x104.
- Async reset mid-run: assert reset between edges at PC_Out=0x40 -> PC_Out=RESET_PC and IFID_valid=0 before the next rising edge. With IF_PERF_CNT_EN, both counters read 0.
